// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
// Shared constants for the instruction-memory loader and anything that walks
// instruction memory alongside it (the program counter steps by ADDR_STEP too).
//
// State encoding: a 2-bit state register holds WAIT_COUNT/BYTES/WRITE/DONE.
// ERROR is not a fifth state. It is a separate err flag that is raised while
// the state register sits in WAIT_COUNT. While err is set it forces the idle
// outputs: in_ready=0, no writes and proc_reset=1.
// -----------------------------------------------------------------------------
package instr_loader_pkg;

  localparam logic [1:0] ST_WAIT_COUNT = 2'd0;
  localparam logic [1:0] ST_BYTES      = 2'd1;
  localparam logic [1:0] ST_WRITE      = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int ADDR_STEP      = 4;

  // The word index needs one bit beyond clog2(depth). Without it, a full-depth
  // load (N == DEPTH) would wrap back to zero on the last increment.
  function automatic int idx_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// instr_loader_byte_assembler
// Collects four stream bytes into one little-endian 32-bit word. Byte k of a
// word lands in bits [8k+7:8k].
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - synchronous clear of the partial word and the byte index
//   accept      - a byte is being transferred this cycle
//   in_data     - the byte being transferred
//   word_next   - current word with in_data inserted into the active lane
//   word_full   - high in the cycle the 4th byte of a word is accepted
// -----------------------------------------------------------------------------
module instr_loader_byte_assembler
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] in_data,
  output logic [WORD_W-1:0] word_next,
  output logic              word_full
);

  logic [1:0]        byte_idx;
  logic [WORD_W-1:0] word_q;

  // word_next is exposed so the parent can capture the complete word on the
  // same edge that takes the final byte. It does not have to wait a cycle for
  // word_q to catch up.
  always_comb begin
    word_next = word_q;
    word_next[{byte_idx, 3'b000} +: BYTE_W] = in_data;
  end

  assign word_full = accept && (byte_idx == 2'(BYTES_PER_WORD - 1));

  // byte_idx wraps 3 -> 0 naturally, so no explicit reset is needed between
  // words. Each new word overwrites every lane, so stale bytes never leak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q   <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      word_q   <= '0;
      byte_idx <= '0;
    end else if (accept) begin
      word_q   <= word_next;
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Writer side of instruction memory. The first byte of the stream is the word
// count N (1..DEPTH). It is followed by 4*N bytes forming little-endian
// instruction words. Each word is written at byte address word_idx*4. The
// processor is held in reset until the final word is written.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start           - re-arm pulse, honoured only in DONE or ERROR
//   in_data/valid   - byte stream input
//   in_ready        - loader can take a byte this cycle
//   wr_en           - one-cycle instruction memory write strobe
//   wr_addr/wr_data - registered write address/data, stable outside WRITE
//   proc_reset      - processor reset, released only once loading is done
//   done            - program fully loaded
//   err             - illegal word count received
// -----------------------------------------------------------------------------
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              proc_reset,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = idx_width(DEPTH);

  logic [1:0]        state;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  word_idx_inc;
  logic [IDX_W-1:0]  word_count;
  logic [WORD_W-1:0] word_next;
  logic              accept;
  logic              count_accept;
  logic              byte_accept;
  logic              word_full;
  logic              rearm;
  logic              count_bad;

  assign accept       = in_valid && in_ready;
  assign count_accept = accept && (state == ST_WAIT_COUNT);
  assign byte_accept  = accept && (state == ST_BYTES);
  assign word_idx_inc = word_idx + IDX_W'(1);

  // A start pulse only matters once a load has finished or failed. A load in
  // progress ignores it, so a stray pulse cannot corrupt half-written memory.
  assign rearm = start && (err || (state == ST_DONE));

  assign count_bad = (in_data == '0) || (int'(in_data) > DEPTH);

  // Every output is decoded straight from the state register and the err
  // flag. This keeps ERROR as simple as forcing the idle outputs.
  assign in_ready   = !err && ((state == ST_WAIT_COUNT) || (state == ST_BYTES));
  assign wr_en      = !err && (state == ST_WRITE);
  assign done       = !err && (state == ST_DONE);
  assign proc_reset = !done;

  instr_loader_byte_assembler u_byte_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (rearm),
    .accept    (byte_accept),
    .in_data   (in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  // Main control FSM. wr_addr and wr_data are captured on the edge that
  // accepts the last byte of a word. They are therefore already valid during
  // the single WRITE cycle and hold their value afterwards. word_idx advances
  // only when leaving WRITE, so the captured address uses the index of the
  // word currently being written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_WAIT_COUNT;
      err        <= 1'b0;
      word_idx   <= '0;
      word_count <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else if (rearm) begin
      state    <= ST_WAIT_COUNT;
      err      <= 1'b0;
      word_idx <= '0;
    end else begin
      case (state)
        ST_WAIT_COUNT: begin
          if (count_accept) begin
            if (count_bad) begin
              err <= 1'b1;
            end else begin
              word_count <= IDX_W'(in_data);
              state      <= ST_BYTES;
            end
          end
        end
        ST_BYTES: begin
          if (word_full) begin
            wr_data <= word_next;
            wr_addr <= ADDR_W'(word_idx) * ADDR_W'(ADDR_STEP);
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          word_idx <= word_idx_inc;
          if (word_idx_inc == word_count) begin
            state <= ST_DONE;
          end else begin
            state <= ST_BYTES;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_WAIT_COUNT;
        end
      endcase
    end
  end

endmodule
